// File: rtl/toast_writeback.sv
// Writeback stage: WB pipeline register, load alignment and
// result select toward the register file, plus retired count.
module toast_writeback #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          mem_valid_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic                          mem_rd_wr_en_i,
  input  logic [1:0]                    mem_wb_sel_i,
  input  logic [2:0]                    mem_load_type_i,
  input  logic [REG_DATA_WIDTH-1:0]     mem_alu_result_i,
  input  logic [REG_DATA_WIDTH-1:0]     mem_pc_plus4_i,
  input  logic [REG_DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
  output logic                          rd_wr_en_o,
  output logic                          wb_valid_o,
  output logic [63:0]                   instret_o
);

  localparam int W = REG_DATA_WIDTH;
  localparam int A = REGFILE_ADDR_WIDTH;

  logic          valid_q;
  logic [A-1:0]  rd_addr_q;
  logic          rd_wr_en_q;
  logic [1:0]    wb_sel_q;
  logic [2:0]    load_type_q;
  logic [W-1:0]  alu_result_q;
  logic [W-1:0]  pc_plus4_q;
  logic [63:0]   instret_q;

  logic          retire;
  logic [1:0]    off;
  logic          half;
  logic [7:0]    byte_d;
  logic [15:0]   half_d;
  logic [W-1:0]  load_data;

  // WB register: flush wins over stall, stall holds
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_wr_en_q   <= 1'b0;
      wb_sel_q     <= '0;
      load_type_q  <= '0;
      alu_result_q <= '0;
      pc_plus4_q   <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
    end else if (!stall_i) begin
      valid_q      <= mem_valid_i;
      rd_addr_q    <= mem_rd_addr_i;
      rd_wr_en_q   <= mem_rd_wr_en_i;
      wb_sel_q     <= mem_wb_sel_i;
      load_type_q  <= mem_load_type_i;
      alu_result_q <= mem_alu_result_i;
      pc_plus4_q   <= mem_pc_plus4_i;
    end
  end

  // An instruction leaves WB only on an unstalled cycle
  assign retire = valid_q & ~stall_i;

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign off    = alu_result_q[1:0];
  assign half   = alu_result_q[1];
  assign byte_d = dmem_rdata_i[{off, 3'b000} +: 8];
  assign half_d = dmem_rdata_i[{half, 4'b0000} +: 16];

  // Align and extend the loaded value by funct3
  always_comb begin
    load_data = dmem_rdata_i;
    unique case (load_type_q)
      3'b000:  load_data = {{(W-8){byte_d[7]}}, byte_d};
      3'b001:  load_data = {{(W-16){half_d[15]}}, half_d};
      3'b100:  load_data = {{(W-8){1'b0}}, byte_d};
      3'b101:  load_data = {{(W-16){1'b0}}, half_d};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // Result source select for the register file write
  always_comb begin
    rd_wr_data_o = alu_result_q;
    unique case (wb_sel_q)
      2'b01:   rd_wr_data_o = load_data;
      2'b10:   rd_wr_data_o = pc_plus4_q;
      default: rd_wr_data_o = alu_result_q;
    endcase
  end

  assign rd_wr_en_o = valid_q & rd_wr_en_q & (rd_addr_q != '0);
  assign rd_addr_o  = rd_addr_q;
  assign wb_valid_o = valid_q;
  assign instret_o  = instret_q;

endmodule

// File: doc/toast_writeback.md
TOAST_WRITEBACK -- requirements
Module: toast_writeback

Interface
REQ-001 The block SHALL have parameter REG_DATA_WIDTH, default 32, meaning data width of the register file write port.
REQ-002 The block SHALL have parameter REGFILE_ADDR_WIDTH, default 5, meaning the register address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i in 1, rising-edge clock; resetn_i in 1, asynchronous active-low reset.
REQ-004 The block SHALL have port stall_i in 1, meaning hold the WB register and suppress retirement.
REQ-005 The block SHALL have port flush_i in 1, meaning load a bubble into the WB register at the next edge.
REQ-006 The block SHALL have port mem_valid_i in 1, meaning the MEM-stage instruction is valid.
REQ-007 The block SHALL have port mem_rd_addr_i in REGFILE_ADDR_WIDTH, meaning the destination register.
REQ-008 The block SHALL have port mem_rd_wr_en_i in 1, meaning the instruction writes rd.
REQ-009 The block SHALL have port mem_wb_sel_i in 2, meaning result source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-010 The block SHALL have port mem_load_type_i in 3, meaning load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 The block SHALL have port mem_alu_result_i in REG_DATA_WIDTH, meaning the ALU result or load address.
REQ-012 The block SHALL have port mem_pc_plus4_i in REG_DATA_WIDTH, meaning the link value.
REQ-013 The block SHALL have port dmem_rdata_i in REG_DATA_WIDTH, meaning the data memory word, valid in the WB cycle and held stable by memory while stall_i=1.
REQ-014 The block SHALL have port rd_addr_o out REGFILE_ADDR_WIDTH, meaning the register file write address.
REQ-015 The block SHALL have port rd_wr_data_o out REG_DATA_WIDTH, meaning the register file write data.
REQ-016 The block SHALL have port rd_wr_en_o out 1, meaning the register file write enable.
REQ-017 The block SHALL have port wb_valid_o out 1, meaning the WB register holds a valid instruction.
REQ-018 The block SHALL have port instret_o out 64, meaning the retired-instruction count.

Function
REQ-019 The WB register (valid, rd_addr, rd_wr_en, wb_sel, load_type, alu_result, pc_plus4) SHALL capture the mem_* inputs on every rising edge with stall_i=0 and flush_i=0.
REQ-020 With stall_i=1 and flush_i=0, the WB register SHALL hold its value.
REQ-021 flush_i=1 SHALL clear the WB valid bit at the next edge, with priority over stall_i; other fields are don't-care.
REQ-022 rd_wr_en_o SHALL be valid_q AND rd_wr_en_q AND (rd_addr_q != 0), combinational from the WB register; a write to x0 never asserts.
REQ-023 rd_addr_o SHALL equal rd_addr_q and wb_valid_o SHALL equal valid_q.
REQ-024 rd_wr_data_o SHALL select by wb_sel_q: 00/11 alu_result_q, 01 aligned load data, 10 pc_plus4_q.
REQ-025 For LB/LBU, the byte SHALL be dmem_rdata_i[8*off+7:8*off], where off=alu_result_q[1:0], sign-extended for LB and zero-extended for LBU.
REQ-026 For LH/LHU, the halfword SHALL be dmem_rdata_i[16*h+15:16*h], where h=alu_result_q[1], sign-extended for LH and zero-extended for LHU; alu_result_q[0] is ignored.
REQ-027 LW and the undefined load_type codes (011, 110, 111) SHALL pass dmem_rdata_i unmodified.
REQ-028 A retire event SHALL be valid_q=1 AND stall_i=0; each instruction retires exactly once regardless of stall length.
REQ-029 instret_o SHALL increment by 1 on the edge ending each retire event and SHALL wrap from 2^64-1 to 0.
REQ-030 With flush_i=1 and a retire event in the same cycle, the WB instruction SHALL still retire (count +1) while the incoming instruction is discarded.
REQ-031 While stalled, rd_wr_en_o MAY remain asserted for repeated identical writes; the register file write is idempotent.

Reset
REQ-032 On resetn_i=0, all WB register fields and instret_o SHALL clear to 0 asynchronously, so rd_wr_en_o=0, wb_valid_o=0, rd_addr_o=0 and rd_wr_data_o=0 (ALU select of 0).
REQ-033 On reset mid-stall or mid-load, the in-flight instruction SHALL be dropped and not counted; operation resumes at the first edge after deassertion.

Verification
REQ-034 Load sign extension: LB, alu_result=0x1003, dmem_rdata=0x80FF_0000, rd=5 -> rd_wr_data_o=0xFFFF_FF80, rd_wr_en_o=1, rd_addr_o=5.
REQ-035 Load zero extension: LHU, alu_result=0x2002, dmem_rdata=0xBEEF_1234 -> rd_wr_data_o=0x0000_BEEF; LH with the same inputs -> 0xFFFF_BEEF.
REQ-036 x0 and link select: JAL with rd=0 and pc_plus4=0x104 -> rd_wr_en_o=0 while instret increments; with rd=1 -> rd_wr_data_o=0x104, rd_wr_en_o=1.
REQ-037 Stall: a valid ADD is held for 3 stalled cycles, then released -> outputs stable throughout and instret +1 only once, on release.
REQ-038 Flush over stall: stall_i=1 and flush_i=1 with a valid instruction in WB -> next cycle wb_valid_o=0 and rd_wr_en_o=0, with no retire for the held instruction (stalled).
REQ-039 Wrap and reset: with instret preset to 0xFFFF_FFFF_FFFF_FFFF, one retire -> 0; resetn_i asserted mid-cycle -> all outputs are 0 immediately, before the next clock.
